// File: rtl/bist_pkg.sv
// Shared types and default constants for the scan self-test path.
// Both the stimulus LFSR side and the response analyzer import this package.
package bist_pkg;

    typedef enum logic [1:0] {
        SKIP    = 2'd0,
        SHIFT   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int         DEF_SIG_W     = 8;
    localparam logic [7:0] DEF_POLY      = 8'h1D;
    localparam int         DEF_CHAIN_LEN = 8;

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register: shifts left, folds the MSB back through POLY
// and XORs the incoming response bit into bit 0 whenever en is high.
module bist_sisr
    import bist_pkg::*;
#(
    parameter int               SIG_W    = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= SIG_SEED;
        else     sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// Compacts scan-chain unload bursts into a SISR and compares against GOLDEN_SIG.
// Optional BIST_SNAPSHOT_EN adds a per-pattern signature snapshot output.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int               CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int               NUM_PATTERNS = 4,
    parameter int               SKIP_FIRST   = 1,
    parameter int               SIG_W        = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY         = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED     = '0,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0,
    localparam int              PAT_W        = $clog2(NUM_PATTERNS + 1),
    localparam int              BIT_W        = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic [SIG_W-1:0] signature,
    output logic [PAT_W-1:0] pat_cnt,
    output logic             done,
    output logic             pass,
    output logic             proto_err
`ifdef BIST_SNAPSHOT_EN
    ,
    output logic [SIG_W-1:0] snap_sig,
    output logic             snap_valid
`endif
);

    localparam state_e INIT_ST = (SKIP_FIRST != 0) ? SKIP : SHIFT;

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             proto_err_q, proto_err_d;
    logic             sisr_en;
    logic             last_bit;
    logic             pat_done;

    bist_sisr #(
        .SIG_W   (SIG_W),
        .POLY    (POLY),
        .SIG_SEED(SIG_SEED)
    ) u_sisr (
        .clk(clk),
        .rst(rst),
        .en (sisr_en),
        .din(scan_in),
        .sig(signature)
    );

    assign last_bit = (bit_cnt_q == BIT_W'(CHAIN_LEN - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        proto_err_d = proto_err_q;
        sisr_en     = 1'b0;
        pat_done    = 1'b0;
        unique case (state_q)
            SKIP, SHIFT: begin
                if (scan_en) begin
                    sisr_en = (state_q == SHIFT);
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (state_q == SKIP) begin
                            state_d = SHIFT;
                        end else begin
                            pat_done  = 1'b1;
                            pat_cnt_d = pat_cnt_q + 1'b1;
                            if (pat_cnt_d == PAT_W'(NUM_PATTERNS)) state_d = COMPARE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (bit_cnt_q != '0) begin
                    // Burst cut short: keep what was compacted, restart the bit count.
                    proto_err_d = 1'b1;
                    bit_cnt_d   = '0;
                end
            end
            COMPARE: begin
                done_d  = 1'b1;
                pass_d  = (signature == GOLDEN_SIG);
                state_d = DONE;
            end
            DONE: begin
            end
            default: state_d = INIT_ST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_ST;
            bit_cnt_q   <= '0;
            pat_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign pat_cnt   = pat_cnt_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign proto_err = proto_err_q;

`ifdef BIST_SNAPSHOT_EN
    logic [SIG_W-1:0] snap_sig_q, snap_sig_d;
    logic             snap_valid_q, snap_valid_d;
    logic [SIG_W-1:0] sig_next;

    // Same value the SISR loads on the completing bit.
    assign sig_next = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, scan_in};

    always_comb begin
        snap_sig_d   = snap_sig_q;
        snap_valid_d = 1'b0;
        if (pat_done) begin
            snap_sig_d   = sig_next;
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_sig_q   <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_sig_q   <= snap_sig_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_sig   = snap_sig_q;
    assign snap_valid = snap_valid_q;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: two instances (no skip / skip first burst)
// checked every cycle against a burst-level model, plus literal expectations.
module tb_bist_response_analyzer;

    localparam int         CL = 8;
    localparam int         NP = 2;
    localparam logic [7:0] PL = 8'h1D;
    localparam logic [7:0] GS = 8'h00;

    logic clk = 1'b0;
    logic rst, scan_en, scan_in;
    always #5 clk = ~clk;

    logic [7:0] sig0, sig1;
    logic [1:0] pat0, pat1;
    logic       done0, done1, pass0, pass1, perr0, perr1;
`ifdef BIST_SNAPSHOT_EN
    logic [7:0] ssig0, ssig1;
    logic       sv0, sv1;
`endif

    bist_response_analyzer #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SKIP_FIRST(0), .SIG_W(8),
        .POLY(PL), .SIG_SEED(8'h00), .GOLDEN_SIG(GS)) dut0 (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
        .signature(sig0), .pat_cnt(pat0), .done(done0), .pass(pass0), .proto_err(perr0)
`ifdef BIST_SNAPSHOT_EN
        , .snap_sig(ssig0), .snap_valid(sv0)
`endif
    );

    bist_response_analyzer #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SKIP_FIRST(1), .SIG_W(8),
        .POLY(PL), .SIG_SEED(8'h00), .GOLDEN_SIG(GS)) dut1 (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
        .signature(sig1), .pat_cnt(pat1), .done(done1), .pass(pass1), .proto_err(perr1)
`ifdef BIST_SNAPSHOT_EN
        , .snap_sig(ssig1), .snap_valid(sv1)
`endif
    );

    // Burst-level model: bits per burst, bursts seen, whether the skip burst is gone.
    logic [7:0] m_sig[2];
    logic [7:0] m_snap_sig[2];
    int         m_pat[2];
    int         m_burst[2];
    bit         m_done[2], m_pass[2], m_perr[2], m_skipped[2], m_pend[2], m_snap_v[2];

    int  n_chk = 0;
    int  n_pass = 0;
    bit  chk_on = 0;

    function automatic logic [7:0] sisr_step(input logic [7:0] s, input logic b);
        return {s[6:0], 1'b0} ^ (s[7] ? PL : 8'h00) ^ {7'b0, b};
    endfunction

    task automatic model_step(input int k, input bit skip, input bit r, input bit e, input bit d);
        m_snap_v[k] = 0;
        if (r) begin
            m_sig[k] = 8'h00; m_pat[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_perr[k] = 0;
            m_burst[k] = 0; m_skipped[k] = !skip; m_pend[k] = 0; m_snap_sig[k] = 8'h00;
        end else if (m_done[k]) begin
        end else if (m_pend[k]) begin
            m_done[k] = 1; m_pass[k] = (m_sig[k] == GS); m_pend[k] = 0;
        end else if (e) begin
            if (m_skipped[k]) m_sig[k] = sisr_step(m_sig[k], d);
            m_burst[k]++;
            if (m_burst[k] == CL) begin
                m_burst[k] = 0;
                if (!m_skipped[k]) m_skipped[k] = 1;
                else begin
                    m_pat[k]++;
                    m_snap_v[k] = 1; m_snap_sig[k] = m_sig[k];
                    if (m_pat[k] == NP) m_pend[k] = 1;
                end
            end
        end else if (m_burst[k] != 0) begin
            m_perr[k] = 1; m_burst[k] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("sig0", 32'(sig0), 32'(m_sig[0]));   chk("sig1", 32'(sig1), 32'(m_sig[1]));
            chk("pat0", 32'(pat0), 32'(m_pat[0]));   chk("pat1", 32'(pat1), 32'(m_pat[1]));
            chk("done0", 32'(done0), 32'(m_done[0])); chk("done1", 32'(done1), 32'(m_done[1]));
            chk("pass0", 32'(pass0), 32'(m_pass[0])); chk("pass1", 32'(pass1), 32'(m_pass[1]));
            chk("perr0", 32'(perr0), 32'(m_perr[0])); chk("perr1", 32'(perr1), 32'(m_perr[1]));
`ifdef BIST_SNAPSHOT_EN
            chk("snapv0", 32'(sv0), 32'(m_snap_v[0]));     chk("snapv1", 32'(sv1), 32'(m_snap_v[1]));
            chk("snaps0", 32'(ssig0), 32'(m_snap_sig[0])); chk("snaps1", 32'(ssig1), 32'(m_snap_sig[1]));
`endif
        end
    end

    task automatic cyc(input bit r, input bit e, input bit d);
        @(negedge clk);
        rst = r; scan_en = e; scan_in = d;
        @(posedge clk);
        model_step(0, 0, r, e, d);
        model_step(1, 1, r, e, d);
    endtask

    // Sends n bits of data, MSB first, with scan_en high.
    task automatic burst(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, data[CL-1-i]);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1; scan_en = 0; scan_in = 0;
        cyc(1, 0, 0);
        chk_on = 1;
        cyc(1, 0, 0);
        settle();
        chk("rst_sig", 32'(sig0), 32'h00); chk("rst_pat", 32'(pat0), 0);
        chk("rst_done", 32'(done0), 0);     chk("rst_perr", 32'(perr1), 0);

        // Scenario 1: all-zero responses, no skip.
        burst(8'h00, 8); settle(); chk("s1_pat1", 32'(pat0), 1);
        cyc(0, 0, 0);
        burst(8'h00, 8); settle(); chk("s1_pat2", 32'(pat0), 2); chk("s1_nodone", 32'(done0), 0);
        cyc(0, 0, 0); settle();
        chk("s1_done", 32'(done0), 1); chk("s1_pass", 32'(pass0), 1); chk("s1_sig", 32'(sig0), 0);

        // Scenario 2: single leading one.
        cyc(1, 0, 0);
        burst(8'h80, 8); settle(); chk("s2_sig_p1", 32'(sig0), 32'h80);
`ifdef BIST_SNAPSHOT_EN
        chk("s2_snapv1", 32'(sv0), 1); chk("s2_snaps1", 32'(ssig0), 32'h80);
`endif
        cyc(0, 0, 0);
        burst(8'h00, 8); settle(); chk("s2_sig_p2", 32'(sig0), 32'h26);
`ifdef BIST_SNAPSHOT_EN
        chk("s2_snapv2", 32'(sv0), 1); chk("s2_snaps2", 32'(ssig0), 32'h26);
`endif
        cyc(0, 0, 0); settle();
        chk("s2_done", 32'(done0), 1); chk("s2_pass", 32'(pass0), 0);

        // Scenario 3: skipped first burst of ones.
        cyc(1, 0, 0);
        burst(8'hFF, 8); cyc(0, 0, 0); settle(); chk("s3_skip_pat", 32'(pat1), 0); chk("s3_skip_sig", 32'(sig1), 0);
        burst(8'h00, 8); cyc(0, 0, 0);
        burst(8'h00, 8); cyc(0, 0, 0); settle();
        chk("s3_pat", 32'(pat1), 2); chk("s3_done", 32'(done1), 1); chk("s3_pass", 32'(pass1), 1);

        // Scenario 4: short burst.
        cyc(1, 0, 0);
        burst(8'hFF, 5); cyc(0, 0, 0); settle();
        chk("s4_perr", 32'(perr0), 1); chk("s4_pat", 32'(pat0), 0);
        burst(8'h00, 8); settle(); chk("s4_pat_after", 32'(pat0), 1);

        // Scenario 5: reset mid-burst, reset with scan_en, frozen after done.
        cyc(1, 0, 0);
        burst(8'h5A, 8); cyc(0, 0, 0); burst(8'hA5, 4);
        cyc(1, 1, 1); settle();
        chk("s5_rst_pat", 32'(pat0), 0); chk("s5_rst_sig", 32'(sig0), 0);
        burst(8'h3C, 8); burst(8'hC3, 8); cyc(0, 0, 0); settle();
        chk("s5_done", 32'(done0), 1);
        for (int i = 0; i < 12; i++) cyc(0, i[0], i[1]);
        settle(); chk("s5_frozen_pat", 32'(pat0), 2); chk("s5_frozen_done", 32'(done0), 1);

        // Random bursts: mostly full, some short, some double length, occasional reset.
        for (int b = 0; b < 400; b++) begin
            int len, sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      len = int'($urandom_range(1, CL - 1));
            else if (sel == 1) len = 2 * CL;
            else               len = CL;
            if ($urandom_range(0, 24) == 0) cyc(1, $urandom_range(0, 1) == 1, 1'b0);
            for (int i = 0; i < len; i++) cyc(0, 1, $urandom_range(0, 1) == 1);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) cyc(0, 0, $urandom_range(0, 1) == 1);
        end

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
